// File: rtl/edsac_word_modulator.sv
// Serialises EDSAC words into fixed-length bit slots, gating a half-duty carrier during each burst.
// Every word occupies WORD_WIDTH data slots (MSB first) plus one silent spacing slot.
module edsac_word_modulator #(
    parameter int unsigned WORD_WIDTH    = 35,
    parameter int unsigned LEAD_CYCLES   = 14,
    parameter int unsigned MOD_DIV       = 10,
    parameter int unsigned BURST_PERIODS = 12,
    parameter int unsigned GAP_CYCLES    = 135
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  out,
    output logic                  busy,
    output logic                  slot_start
);

    localparam int unsigned HALF_DIV = MOD_DIV / 2;
    localparam int unsigned CYC_MAX  = (LEAD_CYCLES > GAP_CYCLES) ? LEAD_CYCLES : GAP_CYCLES;
    localparam int unsigned CYC_W    = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam int unsigned PH_W     = (MOD_DIV > 1) ? $clog2(MOD_DIV) : 1;
    localparam int unsigned PER_W    = (BURST_PERIODS > 1) ? $clog2(BURST_PERIODS) : 1;
    localparam int unsigned SLOT_W   = $clog2(WORD_WIDTH + 1);
    localparam bit          GAP_ONE  = (GAP_CYCLES == 1);
    localparam int unsigned GAP_PRE  = GAP_ONE ? 0 : GAP_CYCLES - 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEAD  = 2'd1,
        S_BURST = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t                r_state;
    logic [CYC_W-1:0]      r_cyc;
    logic [PH_W-1:0]       r_phase;
    logic [PER_W-1:0]      r_period;
    logic [SLOT_W-1:0]     r_slot;
    logic [WORD_WIDTH-1:0] r_shift;
    logic                  r_ready;
    logic                  r_out;
    logic                  r_busy;
    logic                  r_slot_start;

    logic                  w_accept;
    logic                  w_bit;
    logic                  w_lead_done;
    logic                  w_phase_wrap;
    logic                  w_burst_done;
    logic                  w_gap_done;
    logic                  w_last_slot;
    logic                  w_ready_set;
    logic [PH_W-1:0]       w_phase_nxt;

    // Ready drops combinationally with rst so it is low for the whole reset and high right after.
    assign word_ready   = r_ready && !rst;
    assign out          = r_out;
    assign busy         = r_busy;
    assign slot_start   = r_slot_start;

    assign w_accept     = word_valid && word_ready;
    assign w_bit        = r_shift[WORD_WIDTH-1];
    assign w_lead_done  = (r_cyc == CYC_W'(LEAD_CYCLES - 1));
    assign w_phase_wrap = (r_phase == PH_W'(MOD_DIV - 1));
    assign w_burst_done = w_phase_wrap && (r_period == PER_W'(BURST_PERIODS - 1));
    assign w_gap_done   = (r_cyc == CYC_W'(GAP_CYCLES - 1));
    assign w_last_slot  = (r_slot == SLOT_W'(WORD_WIDTH));
    assign w_phase_nxt  = w_phase_wrap ? '0 : r_phase + PH_W'(1);

    // Raise ready on the edge that enters the final GAP cycle of the spacing slot.
    assign w_ready_set  = w_last_slot &&
                          (GAP_ONE ? (r_state == S_BURST && w_burst_done)
                                   : (r_state == S_GAP && r_cyc == CYC_W'(GAP_PRE)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cyc        <= '0;
            r_phase      <= '0;
            r_period     <= '0;
            r_slot       <= '0;
            r_shift      <= '0;
            r_ready      <= 1'b1;
            r_out        <= 1'b0;
            r_busy       <= 1'b0;
            r_slot_start <= 1'b0;
        end else begin
            r_slot_start <= 1'b0;
            if (w_ready_set) begin
                r_ready <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state      <= S_LEAD;
                        r_shift      <= word_in;
                        r_slot       <= '0;
                        r_cyc        <= '0;
                        r_busy       <= 1'b1;
                        r_slot_start <= 1'b1;
                        r_ready      <= 1'b0;
                    end
                end
                S_LEAD: begin
                    if (w_lead_done) begin
                        r_state  <= S_BURST;
                        r_cyc    <= '0;
                        r_phase  <= '0;
                        r_period <= '0;
                        r_out    <= w_bit;
                    end else begin
                        r_cyc <= r_cyc + CYC_W'(1);
                    end
                end
                S_BURST: begin
                    if (w_burst_done) begin
                        r_state <= S_GAP;
                        r_cyc   <= '0;
                        r_out   <= 1'b0;
                    end else begin
                        r_phase <= w_phase_nxt;
                        if (w_phase_wrap) begin
                            r_period <= r_period + PER_W'(1);
                        end
                        r_out <= w_bit && (w_phase_nxt < PH_W'(HALF_DIV));
                    end
                end
                S_GAP: begin
                    if (!w_gap_done) begin
                        r_cyc <= r_cyc + CYC_W'(1);
                    end else if (!w_last_slot) begin
                        r_state      <= S_LEAD;
                        r_cyc        <= '0;
                        r_slot       <= r_slot + SLOT_W'(1);
                        r_shift      <= r_shift << 1;
                        r_slot_start <= 1'b1;
                    end else if (w_accept) begin
                        r_state      <= S_LEAD;
                        r_shift      <= word_in;
                        r_slot       <= '0;
                        r_cyc        <= '0;
                        r_slot_start <= 1'b1;
                        r_ready      <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_cyc   <= '0;
                        r_slot  <= '0;
                        r_shift <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edsac_word_modulator.sv
// Self-checking bench: a slot-timing reference model feeds a per-cycle scoreboard, plus
// table-driven per-word totals and hand-written back-to-back and mid-burst reset sequences.
module tb_edsac_word_modulator;

    localparam int W        = 35;
    localparam int LEAD     = 14;
    localparam int DIV      = 10;
    localparam int PER      = 12;
    localparam int GAP      = 135;
    localparam int SLOT     = LEAD + PER * DIV + GAP;
    localparam int WORD_CYC = (W + 1) * SLOT;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] word_in;
    logic         word_valid;
    logic         word_ready;
    logic         out;
    logic         busy;
    logic         slot_start;

    edsac_word_modulator #(
        .WORD_WIDTH    (W),
        .LEAD_CYCLES   (LEAD),
        .MOD_DIV       (DIV),
        .BURST_PERIODS (PER),
        .GAP_CYCLES    (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .out        (out),
        .busy       (busy),
        .slot_start (slot_start)
    );

    always #4 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: position within the word since the accept edge.
    bit           m_active = 1'b0;
    int           m_t      = 0;
    logic [W-1:0] m_word   = '0;
    logic [3:0]   exp_q[$];

    int pulses, strobes, busy_cnt, first_rise, last_rise;
    int strobe_q[$];
    int rise_q[$];
    logic prev_out = 1'b0;

    typedef struct {
        logic [W-1:0] word;
        bit           noise;
        int           exp_pulses;
        int           exp_strobes;
        int           exp_busy;
        int           exp_first;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [3:0] expect_now(input logic r);
        int   slot;
        int   pos;
        logic b;
        logic o;
        if (!m_active) return {1'b0, 1'b0, 1'b0, !r};
        slot = m_t / SLOT;
        pos  = m_t % SLOT;
        b    = (slot < W) ? m_word[W-1-slot] : 1'b0;
        o    = b && (pos >= LEAD) && (pos < LEAD + PER * DIV) && (((pos - LEAD) % DIV) < DIV / 2);
        return {o, 1'b1, (pos == 0), (m_t == WORD_CYC - 1) && !r};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        pulses     = 0;
        strobes    = 0;
        busy_cnt   = 0;
        first_rise = -1;
        last_rise  = -1;
        strobe_q.delete();
        rise_q.delete();
    endtask

    // Drive inputs for the next edge, predict the following cycle, then sample at the falling edge.
    task automatic step(input logic r, input logic v, input logic [W-1:0] w);
        logic       pre_ready;
        logic [3:0] got;
        logic [3:0] want;
        rst        = r;
        word_valid = v;
        word_in    = w;
        pre_ready  = (!m_active || m_t == WORD_CYC - 1) && !r;
        if (r) begin
            m_active = 1'b0;
            m_t      = 0;
        end else if (v && pre_ready) begin
            m_active = 1'b1;
            m_t      = 0;
            m_word   = w;
        end else if (m_active) begin
            if (m_t == WORD_CYC - 1) m_active = 1'b0;
            else m_t++;
        end
        exp_q.push_back(expect_now(r));
        @(posedge clk);
        cyc++;
        @(negedge clk);
        want = exp_q.pop_front();
        got  = {out, busy, slot_start, word_ready};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL cycle %0d out/busy/slot_start/ready: got %b expected %b", cyc, got, want);
        end
        if (out === 1'b1 && prev_out !== 1'b1) begin
            pulses++;
            if (first_rise < 0) first_rise = cyc;
            last_rise = cyc;
            rise_q.push_back(cyc);
        end
        prev_out = out;
        if (slot_start === 1'b1) begin
            strobes++;
            strobe_q.push_back(cyc);
        end
        if (busy === 1'b1) busy_cnt++;
    endtask

    initial begin
        #(8 * 200000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int           acc;
        int           s2;
        int           first2;
        logic [W-1:0] noise_w;
        logic [W-1:0] w3;

        vecs[0] = '{word: 35'h7FFFFFFFF, noise: 1'b0, exp_pulses: 420, exp_strobes: 36, exp_busy: WORD_CYC, exp_first: LEAD};
        vecs[1] = '{word: 35'h000000000, noise: 1'b0, exp_pulses: 0,   exp_strobes: 36, exp_busy: WORD_CYC, exp_first: -1};
        vecs[2] = '{word: 35'h400000001, noise: 1'b1, exp_pulses: 24,  exp_strobes: 36, exp_busy: WORD_CYC, exp_first: LEAD};
        vecs[3] = '{word: 35'h2AAAAAAAA, noise: 1'b1, exp_pulses: 204, exp_strobes: 36, exp_busy: WORD_CYC, exp_first: SLOT + LEAD};

        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        check("reset_out", int'(out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_slot_start", int'(slot_start), 0);
        check("reset_ready", int'(word_ready), 0);
        step(1'b0, 1'b0, '0);
        check("ready_after_reset", int'(word_ready), 1);

        for (int k = 0; k < 4; k++) begin
            repeat (3) step(1'b0, 1'b0, '0);
            clear_stats();
            step(1'b0, 1'b1, vecs[k].word);
            acc = cyc;
            for (int i = 1; i < WORD_CYC + 4; i++) begin
                if (vecs[k].noise && i < WORD_CYC - 100 && (i % 7) < 3) begin
                    noise_w = W'({$urandom, $urandom});
                    step(1'b0, 1'b1, ~vecs[k].word ^ noise_w);
                end else begin
                    step(1'b0, 1'b0, '0);
                end
            end
            check("word_pulses", pulses, vecs[k].exp_pulses);
            check("word_strobes", strobes, vecs[k].exp_strobes);
            check("word_busy_cycles", busy_cnt, vecs[k].exp_busy);
            check("word_first_pulse", (first_rise < 0) ? -1 : first_rise - acc, vecs[k].exp_first);
            check("word_strobe_latency", (strobe_q.size() > 0) ? strobe_q[0] - acc : -1, 0);
        end

        // Back-to-back: second word held valid from the first accept onwards.
        repeat (3) step(1'b0, 1'b0, '0);
        clear_stats();
        step(1'b0, 1'b1, 35'h7FFFFFFFF);
        acc = cyc;
        for (int i = 1; i <= WORD_CYC; i++) step(1'b0, 1'b1, 35'h400000001);
        for (int i = 0; i < WORD_CYC + 4; i++) step(1'b0, 1'b0, '0);
        s2 = (strobe_q.size() > 36) ? strobe_q[36] : -1;
        first2 = -1;
        foreach (rise_q[j]) if (first2 < 0 && s2 >= 0 && rise_q[j] >= s2) first2 = rise_q[j];
        check("b2b_strobes", strobes, 72);
        check("b2b_second_accept", (s2 < 0) ? -1 : s2 - acc, WORD_CYC);
        check("b2b_busy_cycles", busy_cnt, 2 * WORD_CYC);
        check("b2b_pulses", pulses, 420 + 24);
        check("b2b_second_first_pulse", (first2 < 0) ? -1 : first2 - s2, LEAD);
        check("b2b_last_pulse", (s2 < 0) ? -1 : last_rise - s2, 34 * SLOT + LEAD + (PER - 1) * DIV);

        // Reset in the middle of a burst of a 1 bit, then a fresh word.
        repeat (3) step(1'b0, 1'b0, '0);
        clear_stats();
        step(1'b0, 1'b1, 35'h7FFFFFFFF);
        for (int i = 1; i <= LEAD + 2; i++) step(1'b0, 1'b0, '0);
        check("pre_reset_out", int'(out), 1);
        step(1'b1, 1'b0, '0);
        check("midword_reset_out", int'(out), 0);
        check("midword_reset_busy", int'(busy), 0);
        check("midword_reset_ready", int'(word_ready), 0);
        step(1'b0, 1'b0, '0);
        check("post_reset_ready", int'(word_ready), 1);
        check("post_reset_out", int'(out), 0);
        clear_stats();
        w3 = 35'h123456789;
        step(1'b0, 1'b1, w3);
        acc = cyc;
        for (int i = 1; i < WORD_CYC + 4; i++) step(1'b0, 1'b0, '0);
        check("after_reset_pulses", pulses, $countones(w3) * PER);
        check("after_reset_strobes", strobes, 36);
        check("after_reset_busy_cycles", busy_cnt, WORD_CYC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/edsac_word_modulator.md
EDSAC_WORD_MODULATOR -- requirements
Module: edsac_word_modulator

Interface
REQ-001 Parameter WORD_WIDTH, default 35: data bits per EDSAC word, excluding the spacing slot.
REQ-002 Parameter LEAD_CYCLES, default 14: idle clocks at the start of each bit slot.
REQ-003 Parameter MOD_DIV, default 10: clocks per carrier period; even, at least 2 (13.5 MHz carrier at 135 MHz clk).
REQ-004 Parameter BURST_PERIODS, default 12: carrier periods per bit burst (0.9 us).
REQ-005 Parameter GAP_CYCLES, default 135: idle clocks after each burst (1.0 us).
REQ-006 Port clk, input, 1: system clock, 135 MHz; all logic on its rising edge.
REQ-007 Port rst, input, 1: one clock; reset is synchronous and active-high.
REQ-008 Port word_in, input, WORD_WIDTH: word to transmit; bit WORD_WIDTH-1 is sent first.
REQ-009 Port word_valid, input, 1: word_in is valid.
REQ-010 Port word_ready, output, 1: the block can accept a word this cycle.
REQ-011 Port out, output, 1: modulated pulse train; drives the delay line input "in".
REQ-012 Port busy, output, 1: a word is being transmitted.
REQ-013 Port slot_start, output, 1: one-cycle strobe on the first clock of each bit slot.

Function
REQ-014 Handshake: a word SHALL be accepted on a clock edge where word_valid=1 and word_ready=1; word_in is latched into a shift register on that edge.
REQ-015 word_ready SHALL be high in IDLE, and on the final GAP cycle of the spacing slot.
REQ-016 word_ready SHALL be low in every other cycle; word_valid presented while word_ready=0 SHALL be ignored.
REQ-017 FSM states SHALL be IDLE, LEAD, BURST and GAP.
REQ-018 Transitions: IDLE->LEAD on accept.
REQ-019 Transition LEAD->BURST after LEAD_CYCLES clocks.
REQ-020 Transition BURST->GAP after BURST_PERIODS*MOD_DIV clocks.
REQ-021 Transition GAP->LEAD after GAP_CYCLES clocks if slots remain.
REQ-022 At the end of the last slot's GAP, the FSM SHALL go to LEAD if a word was accepted on that cycle, else to IDLE.
REQ-023 A word SHALL occupy WORD_WIDTH+1 slots: WORD_WIDTH data slots, MSB first, then one spacing slot carrying 0.
REQ-024 Slot length SHALL be LEAD_CYCLES + BURST_PERIODS*MOD_DIV + GAP_CYCLES clocks (269 with defaults); word length is (WORD_WIDTH+1) times that (9684 clocks).
REQ-025 In BURST with slot bit=1, out SHALL be 1 for the first MOD_DIV/2 clocks of each carrier period and 0 for the rest.
REQ-026 With slot bit=0, and in every LEAD, GAP or IDLE cycle, out SHALL be 0; slot timing SHALL be identical for 0 and 1.
REQ-027 out SHALL be registered and glitch-free.
REQ-028 Latency: for an accept at edge N, slot_start=1 and busy=1 SHALL appear in cycle N+1.
REQ-029 For a 1 MSB, the first out=1 SHALL appear in cycle N+1+LEAD_CYCLES.
REQ-030 Back-to-back words SHALL have no idle cycles between the end of one spacing slot and the next LEAD.
REQ-031 busy SHALL be low only in IDLE.
REQ-032 Slot, carrier-period and cycle counters SHALL be sized by $clog2 of their maximum count and SHALL never wrap mid-word.

Reset
REQ-033 While rst=1: state IDLE, out=0, busy=0, slot_start=0, word_ready=0, all counters 0, shift register 0.
REQ-034 word_ready SHALL be 1 in the first cycle after rst falls.
REQ-035 rst asserted mid-word (any state) SHALL abort the word; out SHALL be 0 from the next edge, and no partial pulse is extended.

Verification
REQ-036 Accept word all-ones (35'h7FFFFFFFF) -> 35 bursts of 12 pulses, each 5 clocks high and 5 low; slot_start every 269 clocks; spacing slot silent; busy high for exactly 9684 clocks.
REQ-037 Accept word 0 -> out never high; busy high for 9684 clocks; 36 slot_start strobes.
REQ-038 Hold word_valid=1 with a second word 35'h400000001 -> second word accepted on cycle 9684 after the first accept; its first pulse appears 14 cycles later; its last data pulse is in slot 35.
REQ-039 Toggle word_valid with a different word_in during a transmission -> ignored; the transmitted pattern matches the originally latched word.
REQ-040 Assert rst for 1 cycle mid-BURST of a 1 bit -> out=0 on the next cycle; word_ready=1 the cycle after rst falls; a new word transmits correctly.
REQ-041 Loopback into delay_line with 20 random words -> each output rising edge is within 1 clk period of accept-derived time plus 1.0 ms.
